// File: rtl/bitnet_pkg.sv
// Shared types and helpers for the binary XNOR neuron units.
package bitnet_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    BWD,
    UPD
  } unit_state_t;

  function automatic logic majority3(
    input logic [2:0] x
  );
    return (x[0] & x[1])
         | (x[0] & x[2])
         | (x[1] & x[2]);
  endfunction

endpackage

// File: rtl/unit_weight_cell.sv
// One trainable weight bit with a saturating confidence counter.
module unit_weight_cell #(
  parameter int   CNT_W    = 2,
  parameter logic INIT_BIT = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic upd_en,
  input  logic d,
  input  logic oscillator,
  output logic w,
  output logic flip
);

  localparam logic [CNT_W-1:0] THR_M1 =
    CNT_W'((2 ** CNT_W) - 2);

  logic             w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    w_d   = w_q;
    cnt_d = cnt_q;
    flip  = 1'b0;
    if (upd_en) begin
      if (w_q == d) begin
        if (cnt_q != '0)
          cnt_d = cnt_q - 1'b1;
      end else if (oscillator) begin
        // enough disagreeing evidence: flip and restart
        if (cnt_q == THR_M1) begin
          w_d   = ~w_q;
          cnt_d = '0;
          flip  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      w_q   <= INIT_BIT;
      cnt_q <= '0;
    end else begin
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  assign w = w_q;

endmodule

// File: rtl/unit3to1.sv
// Trainable 3-to-1 XNOR neuron: majority forward pass,
// lane-wise backward errors and counter-gated weight update.
module unit3to1
  import bitnet_pkg::*;
#(
  parameter int         CNT_W  = 2,
  parameter logic [2:0] INIT_W = 3'b101
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       oscillator,
  input  logic       fd_prop,
  input  logic       bk_prop,
  input  logic [2:0] fin,
  input  logic       bin,
  output logic       control_out,
  output logic       fout,
  output logic [2:0] bout
);

  unit_state_t state_q, state_d;
  logic [2:0]  fin_q, fin_d;
  logic        bin_q, bin_d;
  logic        fout_q, fout_d;
  logic [2:0]  bout_q, bout_d;
  logic        ctrl_q, ctrl_d;
  logic [2:0]  w;
  logic [2:0]  flip;
  logic [2:0]  des;
  logic        upd_en;

  assign upd_en = (state_q == UPD);
  assign des    = ~(fin_q ^ {3{bin_q}});

  for (genvar g = 0; g < 3; g++) begin : g_lane
    unit_weight_cell #(
      .CNT_W    (CNT_W),
      .INIT_BIT (INIT_W[g])
    ) u_cell (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .upd_en     (upd_en),
      .d          (des[g]),
      .oscillator (oscillator),
      .w          (w[g]),
      .flip       (flip[g])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      fin_q   <= '0;
      bin_q   <= 1'b0;
      fout_q  <= 1'b0;
      bout_q  <= '0;
      ctrl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= fin_d;
      bin_q   <= bin_d;
      fout_q  <= fout_d;
      bout_q  <= bout_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fd_prop)
          state_d = FWD;
        else if (bk_prop)
          state_d = BWD;
      end
      FWD:     state_d = IDLE;
      BWD:     state_d = UPD;
      UPD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fin_d  = fin_q;
    bin_d  = bin_q;
    fout_d = fout_q;
    bout_d = bout_q;
    ctrl_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fd_prop)
          fin_d = fin;
        else if (bk_prop)
          bin_d = bin;
      end
      FWD:  fout_d = majority3(~(fin_q ^ w));
      BWD:  bout_d = ~(w ^ {3{bin_q}});
      UPD:  ctrl_d = |flip;
      default: ;
    endcase
  end

  assign fout        = fout_q;
  assign bout        = bout_q;
  assign control_out = ctrl_q;

endmodule
